// File: rtl/tanh_lut_arbiter_pkg.sv
// Shared widths, stage-1 record and output saturation for the tanh LUT arbiter.
package tanh_lut_pkg;
  localparam int X_W      = 8;
  localparam int ADDR_W   = 4;
  localparam int FRAC_W   = 4;
  localparam int Y_W      = 8;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
  // Wide enough for the largest legal NREQ (8)
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [FRAC_W-1:0]   frac;
  } s1_t;

  function automatic logic [Y_W-1:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'h7F;
    else if (v < -10'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction
endpackage

// File: rtl/tanh_lut_arbiter_if.sv
// Requester/consumer bundle: master drives requests and resp_ready, slave is the arbiter.
interface tanh_lut_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        resp_y;

  modport master (
    output req_valid, req_x, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y
  );
  modport slave (
    input  req_valid, req_x, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y
  );
endinterface

// File: rtl/tanh_lut_arbiter_lut.sv
// 16-entry breakpoint table (signed, x = 16*i in Q4.4) plus the next-segment endpoint.
module tanh_lut
  import tanh_lut_pkg::*;
(
  input  logic [ADDR_W-1:0] address,
  output logic [Y_W-1:0]    base,
  output logic [Y_W-1:0]    next_data
);
  localparam logic [Y_W-1:0] LUT [16] = '{
    8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
    8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0
  };

  // Entry 7 is the positive end: flat segment. Entry 15 (x just below 0) rises to lut[0].
  always_comb begin
    base = LUT[address];
    if (address == 4'd7)       next_data = LUT[7];
    else if (address == 4'd15) next_data = LUT[0];
    else                       next_data = LUT[address + 4'd1];
  end
endmodule

// File: rtl/tanh_lut_arbiter.sv
// Round-robin arbiter feeding a shared LUT, with 2-stage lookup/interpolate pipeline.
module tanh_lut_arbiter
  import tanh_lut_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  tanh_lut_arbiter_if.slave bus
);
  s1_t             r_s1;
  logic [IDW-1:0]  r_rr;
  logic            r_resp_valid;
  logic [IDW-1:0]  r_resp_id;
  logic [Y_W-1:0]  r_resp_y;

  logic            w_any, w_adv1, w_adv2;
  logic [IDW-1:0]  w_gnt, w_rr_nxt;
  logic [NREQ-1:0] w_gnt_oh;
  logic [X_W-1:0]  w_x;
  logic [Y_W-1:0]  w_base, w_next;
  logic signed [8:0]  w_diff;
  logic signed [12:0] w_diff13, w_frac13, w_prod, w_sh;
  logic signed [9:0]  w_y10;
  int              j;

  // First valid requester at or above rr, wrapping
  always_comb begin
    w_gnt    = '0;
    w_gnt_oh = '0;
    j        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(r_rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req_valid[j]) begin
        w_gnt    = IDW'(j);
        w_gnt_oh = '0;
        w_gnt_oh[j] = 1'b1;
      end
    end
  end

  assign w_any    = |bus.req_valid;
  assign w_adv2   = !r_resp_valid || bus.resp_ready;
  assign w_adv1   = !r_s1.valid || w_adv2;
  assign w_rr_nxt = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;
  assign w_x      = bus.req_x[int'(w_gnt)*8 +: 8];

  assign bus.req_ready  = w_gnt_oh & {NREQ{w_adv1}};
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_y     = r_resp_y;

  tanh_lut u_lut (
    .address   (r_s1.addr),
    .base      (w_base),
    .next_data (w_next)
  );

  // |diff*frac| <= 255*15 fits 13 signed bits; >>>4 floors toward -inf
  assign w_diff   = {w_next[7], w_next} - {w_base[7], w_base};
  assign w_diff13 = {{4{w_diff[8]}}, w_diff};
  assign w_frac13 = {9'd0, r_s1.frac};
  assign w_prod   = w_diff13 * w_frac13;
  assign w_sh     = w_prod >>> 4;
  assign w_y10    = {{2{w_base[7]}}, w_base} + w_sh[9:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1         <= '0;
      r_rr         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_y     <= '0;
    end else begin
      if (w_adv1) begin
        r_s1.valid <= w_any;
        r_s1.id    <= ID_MAX_W'(w_gnt);
        r_s1.addr  <= w_x[7:4];
        r_s1.frac  <= w_x[3:0];
        if (w_any) r_rr <= w_rr_nxt;
      end
      if (w_adv2) begin
        r_resp_valid <= r_s1.valid;
        r_resp_id    <= r_s1.id[IDW-1:0];
        r_resp_y     <= sat8(w_y10);
      end
    end
  end
endmodule
